decoder_rr_arbiter: RTL and testbench
=====================================

Name: decoder_rr_arbiter

Overview:
- Round-robin arbiter that shares one 2-to-4 select resource between 4 requesters.
- Grants at most one requester at a time, holds the grant while the owner keeps requesting, and preempts after a configurable hold limit when others wait.
- Drives a registered one-hot grant, generated from the granted index plus a valid/enable, in front of chip-select/bus-select datapaths.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles before forced rotation when another requester waits. 0 = unlimited.
- HANDOFF_GAP, 1: 1 = one idle cycle (all grants low) between owners. 0 = back-to-back handoff.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  arbiter enable. 0 = no new grants, and the current grant is released.
- req  input  4  request per requester, level-sensitive.
- gnt  output  4  registered one-hot grant. All zero when no owner.
- gnt_idx  output  2  index of current owner. Holds last owner when gnt_valid=0.
- gnt_valid  output  1  high when a grant is active. Equals |gnt.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Values at reset:
  - state=IDLE, gnt=4'b0000, gnt_valid=0, gnt_idx=2'b00.
  - last_idx=2'b11, so req[0] has top priority after reset.
  - hold_cnt=0.
- All outputs are registered. Latency from a req rising in IDLE to gnt is 1 clock.
- Priority order is last_idx+1, +2, +3, +4 (mod 4, wraps 3->0). The previous owner is therefore always lowest priority.
- IDLE:
  - If en && |req: select the winner by round-robin. Next edge: gnt_idx=winner, gnt=onehot(winner), gnt_valid=1, hold_cnt=1, go BUSY.
  - Otherwise stay in IDLE with outputs low.
- BUSY (owner o = gnt_idx), each edge:
  - Release when req[o]=0 OR en=0. Set gnt=0, gnt_valid=0, last_idx=o, hold_cnt=0.
    - HANDOFF_GAP=1: go GAP.
    - HANDOFF_GAP=0: go IDLE. If en and other requests are pending, the IDLE decision happens on the following edge, so a 1-cycle gap still occurs on release.
  - Preempt when MAX_HOLD!=0 && hold_cnt==MAX_HOLD && |(req & ~onehot(o)). Handled the same as release (gnt drops, last_idx=o).
  - Otherwise stay in BUSY. hold_cnt increments, saturating at MAX_HOLD.
- Preempt with HANDOFF_GAP=0:
  - Transition goes directly BUSY->BUSY with the new winner, chosen from req excluding o.
  - The new gnt appears on the same edge the old one drops, with no idle cycle.
  - hold_cnt=1.
- GAP: exactly one cycle with gnt=0, then IDLE. Not entered when HANDOFF_GAP=0.
- hold_cnt width is max(1, $clog2(MAX_HOLD+1)).
- When MAX_HOLD=0, preemption never occurs and the owner keeps the grant indefinitely.
- Requests dropping and rising on the same edge are sampled as seen at that edge. No request latching: a req pulse that is low at the sampling edge is lost.
- en=0 with no owner: remains IDLE. en=0 during GAP: GAP completes normally.
- Reset asserted mid-grant: gnt drops immediately (asynchronously) and priority returns to req[0] first.
- Invariants, checked by assertions:
  - $onehot0(gnt).
  - gnt_valid == |gnt.
  - gnt == onehot(gnt_idx) when gnt_valid.
  - gnt[i] only rises while req[i]=1 in the previous cycle.

Decomposition:
- Shared package arb_pkg holds:
  - state enum {IDLE, BUSY, GAP};
  - function rr_pick(req[3:0], last[1:0]) returning {found, idx[1:0]};
  - constant N_REQ=4.
- Natural sub-module: the existing decoder_2to4. Feed it next-state idx as input and next gnt_valid as enable; register its output into gnt.

Test Plan:
1. Reset then req=4'b1111 held, MAX_HOLD=8, HANDOFF_GAP=1 -> grants cycle 0,1,2,3,0. Each owner holds 8 cycles, then 1 gap cycle. First gnt=4'b0001 one clock after req.
2. req=4'b0100 for 3 cycles then 0 -> gnt=4'b0100 for 3 cycles, then 0. Next req=4'b0101 -> grant goes to idx 0, since last_idx=2 puts priority order 3,0,1.
3. MAX_HOLD=0, req=4'b0011 held 50 cycles -> gnt stays 4'b0001 all 50 cycles, no preemption.
4. HANDOFF_GAP=0, MAX_HOLD=4, req=4'b1001 held -> gnt 0001 x4, then 1000 x4 with no zero cycle between, then 0001.
5. Owner idx1 granted, en dropped for 2 cycles -> gnt=0 the following edge and stays 0 while en=0. en back with req=4'b0010 -> regrant idx1 after 1 clock.
6. rst_n asserted low mid-grant (gnt=4'b1000) between clock edges -> gnt=0 immediately. After release with req=4'b1001 -> idx0 wins.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the decoder_rr_arbiter block.
//   state_t  : arbiter FSM states
//   pick_t   : result of a round-robin search {found, idx}
//   rr_pick  : round-robin winner search, priority last+1, +2, +3, +4 (mod 4)
//   N_REQ    : number of requesters
package arb_pkg;

    localparam int N_REQ = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

    // The search walks from the farthest candidate (last+4, i.e. last itself)
    // towards the nearest (last+1), so the nearest requesting index is the
    // one left standing. The previous owner therefore always ranks lowest.
    function automatic pick_t rr_pick(input logic [3:0] req, input logic [1:0] last);
        pick_t      res;
        logic [1:0] cand;
        res = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = last + 2'(k);
            if (req[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/decoder_2to4.sv
// 2-to-4 one-hot decoder with enable.
//   idx    : input index to decode
//   en     : when low, all outputs are zero
//   onehot : onehot(idx) when en, else 4'b0000
module decoder_2to4 (
    input  logic [1:0] idx,
    input  logic       en,
    output logic [3:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter sharing one 2-to-4 select resource among 4 requesters.
// The grant is held while the owner keeps requesting and is preempted after
// MAX_HOLD consecutive cycles when someone else is waiting.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   en        : arbiter enable; low releases the current grant, blocks new ones
//   req       : level-sensitive request per requester
//   gnt       : registered one-hot grant, zero when no owner
//   gnt_idx   : current owner index, holds the last owner when gnt_valid=0
//   gnt_valid : grant active, equals |gnt
// Parameters:
//   MAX_HOLD    : grant cycles before forced rotation (0 = unlimited)
//   HANDOFF_GAP : 1 = idle cycle between owners, 0 = back-to-back preemption
module decoder_rr_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD    = 8,
    parameter int HANDOFF_GAP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [1:0]       gnt_idx,
    output logic             gnt_valid
);

    localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    state_t            state, state_nx;
    logic [1:0]        last_idx, last_nx, idx_nx;
    logic              valid_nx;
    logic [HOLD_W-1:0] hold_cnt, hold_nx;
    logic [N_REQ-1:0]  owner_mask, gnt_nx;
    pick_t             pick_all, pick_others;

    assign owner_mask  = 4'b0001 << gnt_idx;
    assign pick_all    = rr_pick(req, last_idx);
    assign pick_others = rr_pick(req & ~owner_mask, gnt_idx);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nx = state;
        idx_nx   = gnt_idx;
        valid_nx = 1'b0;
        last_nx  = last_idx;
        hold_nx  = hold_cnt;

        case (state)
            // GAP is the single zero-grant cycle between owners; its exit edge
            // arbitrates exactly like IDLE so only one idle cycle is inserted.
            IDLE, GAP: begin
                if (en && pick_all.found) begin
                    state_nx = BUSY;
                    idx_nx   = pick_all.idx;
                    valid_nx = 1'b1;
                    hold_nx  = HOLD_W'(1);
                end else begin
                    state_nx = IDLE;
                end
            end

            BUSY: begin
                if (!req[gnt_idx] || !en) begin
                    last_nx  = gnt_idx;
                    hold_nx  = '0;
                    state_nx = (HANDOFF_GAP != 0) ? GAP : IDLE;
                end else if (MAX_HOLD != 0 && hold_cnt == HOLD_MAX && pick_others.found) begin
                    last_nx = gnt_idx;
                    if (HANDOFF_GAP == 0) begin
                        // Direct handoff: new grant lands on the edge the old one drops.
                        idx_nx   = pick_others.idx;
                        valid_nx = 1'b1;
                        hold_nx  = HOLD_W'(1);
                    end else begin
                        hold_nx  = '0;
                        state_nx = GAP;
                    end
                end else begin
                    valid_nx = 1'b1;
                    if (MAX_HOLD != 0 && hold_cnt != HOLD_MAX) begin
                        hold_nx = hold_cnt + 1'b1;
                    end
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    // The decoder works on next-state values so gnt is a plain register.
    decoder_2to4 u_dec (
        .idx    (idx_nx),
        .en     (valid_nx),
        .onehot (gnt_nx)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= 2'b00;
            last_idx  <= 2'b11;
            hold_cnt  <= '0;
        end else begin
            state     <= state_nx;
            gnt       <= gnt_nx;
            gnt_valid <= valid_nx;
            gnt_idx   <= idx_nx;
            last_idx  <= last_nx;
            hold_cnt  <= hold_nx;
        end
    end

    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_valid:  assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == (|gnt));
    a_idx:    assert property (@(posedge clk) disable iff (!rst_n)
                               gnt_valid |-> gnt == (4'b0001 << gnt_idx));

    for (genvar i = 0; i < N_REQ; i++) begin : g_rise
        a_rise: assert property (@(posedge clk) disable iff (!rst_n)
                                 $rose(gnt[i]) |-> $past(req[i]));
    end

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Self-checking bench for decoder_rr_arbiter. Three instances with different
// parameter sets share one stimulus: A (8,1), B (0,1), C (4,0).
module tb_decoder_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] req;

    logic [3:0] gnt_a, gnt_b, gnt_c;
    logic [1:0] idx_a, idx_b, idx_c;
    logic       val_a, val_b, val_c;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    decoder_rr_arbiter #(.MAX_HOLD(8), .HANDOFF_GAP(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(val_a));

    decoder_rr_arbiter #(.MAX_HOLD(0), .HANDOFF_GAP(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(val_b));

    decoder_rr_arbiter #(.MAX_HOLD(4), .HANDOFF_GAP(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .gnt(gnt_c), .gnt_idx(idx_c), .gnt_valid(val_c));

    // Reference model: who owns the bus, who had it last, how long it has held.
    typedef struct {
        int owner;   // -1 = nobody
        int idx;     // reported index (sticks after release)
        int last;
        int hold;
    } mdl_t;

    typedef struct {
        logic [3:0] req;
        logic       en;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       valid;
    } vec_t;

    mdl_t ma, mb, mc;
    vec_t tbl[17];

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.owner = -1;
        m.idx   = 0;
        m.last  = 3;
        m.hold  = 0;
        return m;
    endfunction

    function automatic int rr(input int r, input int last);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (last + k) % 4;
            if (((r >> c) & 1) != 0) return c;
        end
        return -1;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input int r, input bit e,
                                      input int mh, input int hg);
        mdl_t n;
        int   o, oth, w;
        n = m;
        if (m.owner < 0) begin
            if (e && r != 0) begin
                w       = rr(r, m.last);
                n.owner = w;
                n.idx   = w;
                n.hold  = 1;
            end
            return n;
        end
        o = m.owner;
        if (!e || ((r >> o) & 1) == 0) begin
            n.last  = o;
            n.owner = -1;
            n.hold  = 0;
            return n;
        end
        oth = r & ~(1 << o);
        if (mh != 0 && m.hold >= mh && oth != 0) begin
            n.last = o;
            if (hg != 0) begin
                n.owner = -1;
                n.hold  = 0;
            end else begin
                w       = rr(oth, o);
                n.owner = w;
                n.idx   = w;
                n.hold  = 1;
            end
            return n;
        end
        if (mh != 0 && m.hold < mh) n.hold = m.hold + 1;
        return n;
    endfunction

    function automatic logic [6:0] mdl_out(input mdl_t m);
        logic [3:0] g;
        logic [1:0] ix;
        g  = (m.owner >= 0) ? 4'(1 << m.owner) : 4'b0000;
        ix = 2'(m.idx);
        return {(m.owner >= 0), ix, g};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        en    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // {req, en} applied before the edge, {gnt, idx, valid} expected after it (DUT A)
        tbl[0]  = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1};
        tbl[1]  = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1};
        tbl[2]  = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1};
        tbl[3]  = '{4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0};
        tbl[4]  = '{4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0};
        tbl[5]  = '{4'b0101, 1'b1, 4'b0001, 2'd0, 1'b1};
        tbl[6]  = '{4'b0101, 1'b1, 4'b0001, 2'd0, 1'b1};
        tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
        tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
        tbl[9]  = '{4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1};
        tbl[10] = '{4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1};
        tbl[11] = '{4'b0010, 1'b0, 4'b0000, 2'd1, 1'b0};
        tbl[12] = '{4'b0010, 1'b0, 4'b0000, 2'd1, 1'b0};
        tbl[13] = '{4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1};
        tbl[14] = '{4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1};
        tbl[15] = '{4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0};
        tbl[16] = '{4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0};

        // Reset values, checked while reset is held.
        rst_n = 1'b0;
        req   = 4'b0000;
        en    = 1'b0;
        tick();
        check("reset_a", {val_a, idx_a, gnt_a}, 7'b0_00_0000);
        check("reset_b", {val_b, idx_b, gnt_b}, 7'b0_00_0000);
        check("reset_c", {val_c, idx_c, gnt_c}, 7'b0_00_0000);
        rst_n = 1'b1;

        // Table: single holder, round-robin after release, enable drop.
        for (int i = 0; i < 17; i++) begin
            req = tbl[i].req;
            en  = tbl[i].en;
            tick();
            check($sformatf("tbl%0d", i), {val_a, idx_a, gnt_a},
                  {tbl[i].valid, tbl[i].idx, tbl[i].gnt});
        end

        // Full contention with hold limit 8 and one idle cycle per handoff.
        do_reset();
        req = 4'b1111;
        en  = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) begin
                tick();
                check($sformatf("rotate_own%0d_cyc%0d", r, c), gnt_a, 32'(1) << r);
            end
            tick();
            check($sformatf("rotate_gap%0d", r), {val_a, gnt_a}, 5'b0_0000);
        end
        tick();
        check("rotate_wrap", gnt_a, 4'b0001);

        // Unlimited hold: owner 0 never preempted.
        do_reset();
        req = 4'b0011;
        en  = 1'b1;
        for (int c = 0; c < 50; c++) begin
            tick();
            check($sformatf("nohold_cyc%0d", c), gnt_b, 4'b0001);
        end

        // Back-to-back preemption, hold limit 4.
        do_reset();
        req = 4'b1001;
        en  = 1'b1;
        for (int c = 0; c < 9; c++) begin
            tick();
            check($sformatf("b2b_cyc%0d", c), gnt_c, (c < 4 || c == 8) ? 4'b0001 : 4'b1000);
        end

        // Asynchronous reset in the middle of a grant.
        do_reset();
        req = 4'b1000;
        en  = 1'b1;
        tick();
        check("pre_async_rst", gnt_a, 4'b1000);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_drop", {val_a, gnt_a}, 5'b0_0000);
        tick();
        rst_n = 1'b1;
        req   = 4'b1001;
        tick();
        check("after_rst_prio", {val_a, idx_a, gnt_a}, 7'b1_00_0001);

        // Randomized traffic against the reference model, all three configs.
        do_reset();
        ma = mdl_reset();
        mb = mdl_reset();
        mc = mdl_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            en = ($urandom_range(0, 19) != 0);
            tick();
            ma = mdl_step(ma, int'(req), en, 8, 1);
            mb = mdl_step(mb, int'(req), en, 0, 1);
            mc = mdl_step(mc, int'(req), en, 4, 0);
            check($sformatf("rand_a_%0d", c), {val_a, idx_a, gnt_a}, mdl_out(ma));
            check($sformatf("rand_b_%0d", c), {val_b, idx_b, gnt_b}, mdl_out(mb));
            check($sformatf("rand_c_%0d", c), {val_c, idx_c, gnt_c}, mdl_out(mc));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
